// File: rtl/program_memory_server.sv
// program_memory_server: program memory serving round-robin byte fetches with a host load port.
// Loads take priority over fetches. Each response returns READ_LATENCY cycles after its grant.
module program_memory_server #(
   parameter int NUM_FETCHERS = 4,
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_FETCHERS-1:0]           fetch_req,
   input  logic [NUM_FETCHERS*ADDR_BITS-1:0] fetch_addr,
   output logic [NUM_FETCHERS-1:0]           fetch_ack,
   output logic [NUM_FETCHERS-1:0]           resp_valid,
   output logic [DATA_BITS-1:0]              resp_data,
   input  logic                              load_valid,
   input  logic [ADDR_BITS-1:0]              load_addr,
   input  logic [DATA_BITS-1:0]              load_data,
   output logic                              load_ready
);
   localparam int PW = NUM_FETCHERS > 1 ? $clog2(NUM_FETCHERS) : 1;
   logic [DATA_BITS-1:0]    mem [2**ADDR_BITS];
   logic [PW-1:0]           ptr, gnt_idx;
   logic                    found, do_grant;
   logic [NUM_FETCHERS-1:0] grant;
   logic [ADDR_BITS-1:0]    rd_addr;
   logic [NUM_FETCHERS-1:0] pg [READ_LATENCY];
   logic [DATA_BITS-1:0]    pd [READ_LATENCY];
   int                      j;
   // First requester at or after the pointer, wrapping around.
   always_comb begin
      gnt_idx = '0;
      found = 1'b0;
      j = 0;
      for (int i = 0; i < NUM_FETCHERS; i++) begin
         j = int'(ptr) + i;
         j = j >= NUM_FETCHERS ? j - NUM_FETCHERS : j;
         if (!found && fetch_req[j]) begin
            found = 1'b1;
            gnt_idx = PW'(j);
         end
      end
   end
   assign do_grant   = found & ~load_valid & ~reset;
   assign grant      = do_grant ? NUM_FETCHERS'(1) << gnt_idx : '0;
   assign rd_addr    = fetch_addr[gnt_idx*ADDR_BITS +: ADDR_BITS];
   assign fetch_ack  = grant;
   assign load_ready = ~reset;
   assign resp_valid = pg[READ_LATENCY-1];
   assign resp_data  = pd[READ_LATENCY-1];
   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (do_grant)
         ptr <= gnt_idx == PW'(NUM_FETCHERS - 1) ? '0 : gnt_idx + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (load_valid && !reset)
         mem[load_addr] <= load_data;
   end
   // Data stages only advance with a valid grant, so the last stage holds the previous response.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < READ_LATENCY; k++) begin
            pg[k] <= '0;
            pd[k] <= '0;
         end
      end else begin
         pg[0] <= grant;
         if (do_grant)
            pd[0] <= mem[rd_addr];
         for (int k = 1; k < READ_LATENCY; k++) begin
            pg[k] <= pg[k-1];
            if (|pg[k-1])
               pd[k] <= pd[k-1];
         end
      end
   end
endmodule

// File: doc/program_memory_server.md
Name: program_memory_server

Overview:
- Responder end of the instruction-fetch interface. Holds the program memory and serves byte-wide fetch requests from NUM_FETCHERS core fetchers.
- Arbitrates among fetchers round-robin and returns data after a fixed READ_LATENCY pipeline.
- A host load port writes the program image into the same memory. Load traffic has priority over fetch traffic.

Parameters:
- NUM_FETCHERS, 4, number of fetch requesters (1..16)
- ADDR_BITS, 8, program memory address width; depth = 2^ADDR_BITS
- DATA_BITS, 8, instruction width
- READ_LATENCY, 2, cycles from grant to response (1..4)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fetch_req  in  NUM_FETCHERS  per-fetcher request; held high with address until acked
- fetch_addr  in  NUM_FETCHERS*ADDR_BITS  flattened addresses; fetcher i uses slice [i*ADDR_BITS +: ADDR_BITS]
- fetch_ack  out  NUM_FETCHERS  one-hot, one-cycle pulse: request accepted this cycle
- resp_valid  out  NUM_FETCHERS  one-hot, one-cycle pulse: resp_data belongs to that fetcher
- resp_data  out  DATA_BITS  instruction returned (shared bus)
- load_valid  in  1  host write request
- load_addr  in  ADDR_BITS  host write address
- load_data  in  DATA_BITS  host write data
- load_ready  out  1  write accepted this cycle (constant 1 outside reset)

Behaviour:
- Reset, in the cycle reset is sampled high:
  - fetch_ack=0, resp_valid=0, resp_data=0, load_ready=0.
  - Round-robin pointer=0. All in-flight pipeline entries discarded; no responses issue after reset.
  - Memory contents are not cleared.
- Cycle arbitration:
  - If load_valid=1 (and not reset): write mem[load_addr]=load_data at this edge, load_ready=1, and no fetch grant this cycle.
  - Otherwise, if any fetch_req bit is set: grant the first requester at index >= pointer, wrapping modulo NUM_FETCHERS.
    - fetch_ack[g]=1 in that same cycle (combinational from the registered pointer and inputs).
    - Pointer <= (g+1) mod NUM_FETCHERS.
  - No requests: pointer unchanged, no ack.
- Fetcher protocol:
  - Fetcher holds fetch_req[i] and its address until it sees fetch_ack[i]. It may drop or re-raise req in the following cycle.
  - A fetcher may have a new request acked while its previous response is still in flight. Responses return in grant order.
- Read pipeline:
  - On grant in cycle N, address and one-hot grant enter a READ_LATENCY-deep shift pipeline. Memory read happens at stage 0.
  - resp_valid/resp_data are registered and asserted in cycle N+READ_LATENCY for exactly one cycle.
  - Throughput: one grant and one response per cycle, sustained.
  - resp_data holds its last value when resp_valid=0.
- Read/write ordering:
  - A write at edge N is visible to any fetch granted in cycle N+1 or later.
  - A fetch granted in the same cycle as a write is impossible, because the load blocks the grant.
- Address wrap: addresses are ADDR_BITS wide. No out-of-range case exists, and addr 2^ADDR_BITS-1 is valid.
- Simultaneous events:
  - load_valid plus all fetch_req high: load wins; fetchers keep waiting; pointer frozen.
  - Continuous loads starve fetch. This is intended: the host loads before launching the cores.
- Reset mid-operation:
  - Pending acks are suppressed and pipeline entries are dropped. Fetchers must re-request after reset.
- Single fetcher (NUM_FETCHERS=1): pointer is constant 0; grant whenever req=1 and no load.

Test Plan:
- Load mem[0..3]=0x10,0x11,0x12,0x13 via load port, then fetcher 0 requests addr 2 -> fetch_ack[0] in grant cycle; resp_valid=4'b0001, resp_data=0x12 exactly 2 cycles later.
- All four fetchers request simultaneously and continuously (addr = 0,1,2,3) from pointer 0 -> acks in order 0,1,2,3,0,... one per cycle; responses 0x10,0x11,0x12,0x13 each 2 cycles after its ack, with matching resp_valid bits.
- load_valid held for 3 cycles while fetch_req=4'b1111 -> no fetch_ack during those cycles; load_ready=1 each cycle; arbitration resumes at the frozen pointer afterwards.
- Write mem[5]=0xAA at edge N, fetcher 1 requests addr 5 in cycle N+1 -> response 0xAA (not the old value) at N+3.
- Fetcher 2 acked, then reset asserted in the next cycle -> no resp_valid ever appears for that request; all outputs 0 during reset; memory still holds loaded values after reset.
- Fetch addr 0xFF after loading mem[0xFF]=0x7E -> resp_data=0x7E; back-to-back requests to 0xFF and 0x00 return in grant order.
